// File: rtl/gmii_tx_arb_pkg.sv
// gmii_tx_arb_pkg: shared FSM state type, default parameters and counter widths for the GMII TX arbiter
package gmii_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, IFG} state_e;
  localparam int IFG_DEFAULT    = 12;
  localparam int JABBER_DEFAULT = 1522;
  localparam int BCNT_W         = 11;
  localparam int IFG_W          = 16;
endpackage

// File: rtl/gmii_ifg_timer.sv
// gmii_ifg_timer: loadable down-counter; clk/rst_n, load+load_val preset, dec counts down, done when zero
module gmii_ifg_timer
  import gmii_tx_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IFG_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);
  logic [IFG_W-1:0] cnt_q;
  assign done = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (dec && !done) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: round-robin two-port GMII TX arbiter with IFG enforcement and jabber cut-off
// Ports: TxClk/rst_n; ReqA/B in, GntA/B out; TxDA/B, TxEnA/B, TxErrA/B requester GMII in;
// TxD/TxEn/TxErr arbitrated GMII out (one-cycle delay); ClkEN converter enable; Jabber pulse;
// FrameCntA/B completed-frame counters, live only with GMII_TX_ARBITER_STATS_EN defined.
module gmii_tx_arbiter
  import gmii_tx_arb_pkg::*;
#(
  parameter int IFG_BYTES       = IFG_DEFAULT,
  parameter int MAX_FRAME_BYTES = JABBER_DEFAULT
) (
  input  logic        TxClk,
  input  logic        rst_n,
  input  logic        ReqA,
  input  logic        ReqB,
  output logic        GntA,
  output logic        GntB,
  input  logic [7:0]  TxDA,
  input  logic [7:0]  TxDB,
  input  logic        TxEnA,
  input  logic        TxEnB,
  input  logic        TxErrA,
  input  logic        TxErrB,
  output logic [7:0]  TxD,
  output logic        TxEn,
  output logic        TxErr,
  output logic        ClkEN,
  output logic        Jabber,
  output logic [15:0] FrameCntA,
  output logic [15:0] FrameCntB
);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_BYTES - 1);
  state_e st_q;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic ptr_q, hist_q, req_g, en_g, err_g, pick_b, jab, eof, rel, stay, ifg_done;
  logic [7:0] d_g;
  assign req_g  = GntB ? ReqB : ReqA;
  assign en_g   = GntB ? TxEnB : TxEnA;
  assign err_g  = GntB ? TxErrB : TxErrA;
  assign d_g    = GntB ? TxDB : TxDA;
  // ptr_q is the last granted port; until the first grant a tie goes to A
  assign pick_b = ReqB && (!ReqA || (hist_q && !ptr_q));
  assign jab    = st_q == GRANT && en_g && bcnt_q == BCNT_W'(MAX_FRAME_BYTES);
  // output TxEn is the granted TxEn one cycle late, so it doubles as the previous-cycle value
  assign eof    = st_q == GRANT && !en_g && TxEn;
  assign rel    = st_q == GRANT && !en_g && !req_g && bcnt_q == '0;
  assign stay   = st_q == GRANT && !(jab || eof || rel);
  assign bcnt_d = (en_g && !(&bcnt_q)) ? bcnt_q + 1'b1 : bcnt_q;
  gmii_ifg_timer u_ifg (
    .clk     (TxClk),
    .rst_n   (rst_n),
    .load    (jab || eof),
    .load_val(IFG_LOAD),
    .dec     (st_q == IFG),
    .done    (ifg_done)
  );
  always_ff @(posedge TxClk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= IDLE;
      GntA   <= 1'b0;
      GntB   <= 1'b0;
      TxD    <= '0;
      TxEn   <= 1'b0;
      TxErr  <= 1'b0;
      Jabber <= 1'b0;
      ClkEN  <= 1'b0;
      bcnt_q <= '0;
      ptr_q  <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      ClkEN  <= 1'b1;
      Jabber <= jab;
      TxD    <= stay ? d_g : 8'h00;
      TxEn   <= stay && en_g;
      TxErr  <= stay && err_g;
      case (st_q)
        IDLE:
          if (ReqA || ReqB) begin
            st_q   <= GRANT;
            GntA   <= !pick_b;
            GntB   <= pick_b;
            ptr_q  <= pick_b;
            hist_q <= 1'b1;
            bcnt_q <= '0;
          end
        GRANT:
          if (jab || eof) begin
            st_q <= (IFG_BYTES == 0) ? IDLE : IFG;
            GntA <= 1'b0;
            GntB <= 1'b0;
          end else if (rel) begin
            st_q <= IDLE;
            GntA <= 1'b0;
            GntB <= 1'b0;
          end else bcnt_q <= bcnt_d;
        IFG: if (ifg_done) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
`ifdef GMII_TX_ARBITER_STATS_EN
  logic [15:0] fca_q, fcb_q;
  always_ff @(posedge TxClk or negedge rst_n)
    if (!rst_n) begin
      fca_q <= '0;
      fcb_q <= '0;
    end else if (jab || eof) begin
      if (GntB) fcb_q <= fcb_q + 1'b1;
      else fca_q <= fca_q + 1'b1;
    end
  assign FrameCntA = fca_q;
  assign FrameCntB = fcb_q;
`else
  assign FrameCntA = '0;
  assign FrameCntB = '0;
`endif
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter: scoreboard bench for gmii_tx_arbiter (byte and grant queues checked by a negedge monitor)
module tb_gmii_tx_arbiter;
  import gmii_tx_arb_pkg::*;
  localparam int GAP = IFG_DEFAULT + 1;
`ifdef GMII_TX_ARBITER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  typedef struct {bit b; int gap;} gexp_t;
  logic TxClk, rst_n, ReqA, ReqB, GntA, GntB, TxEnA, TxEnB, TxErrA, TxErrB;
  logic TxEn, TxErr, ClkEN, Jabber;
  logic [7:0] TxDA, TxDB, TxD;
  logic [15:0] FrameCntA, FrameCntB;
  logic [8:0] bq[$];
  gexp_t gq[$];
  int cmp = 0, bad = 0, jab_n = 0, glow = 0;
  gmii_tx_arbiter dut (
    .TxClk(TxClk), .rst_n(rst_n), .ReqA(ReqA), .ReqB(ReqB), .GntA(GntA), .GntB(GntB),
    .TxDA(TxDA), .TxDB(TxDB), .TxEnA(TxEnA), .TxEnB(TxEnB), .TxErrA(TxErrA), .TxErrB(TxErrB),
    .TxD(TxD), .TxEn(TxEn), .TxErr(TxErr), .ClkEN(ClkEN), .Jabber(Jabber),
    .FrameCntA(FrameCntA), .FrameCntB(FrameCntB)
  );
  initial TxClk = 1'b0;
  always #5 TxClk = ~TxClk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input bit b, input logic r, input logic e, input logic x, input logic [7:0] d);
    if (b) begin
      ReqB = r; TxEnB = e; TxErrB = x; TxDB = d;
    end else begin
      ReqA = r; TxEnA = e; TxErrA = x; TxDA = d;
    end
  endtask
  task automatic wait_gnt(input bit b);
    int t = 0;
    while ((b ? GntB : GntA) !== 1'b1 && t < 4000) begin
      @(posedge TxClk); #1;
      t++;
    end
    if (t >= 4000) chk("gnt_wait", 32'(b ? GntB : GntA), 1);
  endtask
  // drives n bytes once granted; only the first keep_n are expected on the output
  task automatic frame(input bit b, input int n, input int err_at, input int keep_n);
    int t = 0;
    logic [7:0] d;
    drive(b, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_gnt(b);
    for (int i = 0; i < n; i++) begin
      d = 8'(i * 3 + (b ? 8'h80 : 8'h11));
      drive(b, b ? GntB : GntA, 1'b1, i == err_at, d);
      if (i < keep_n) bq.push_back({i == err_at, d});
      @(posedge TxClk); #1;
    end
    drive(b, b ? GntB : GntA, 1'b0, 1'b0, 8'h00);
    while ((b ? GntB : GntA) === 1'b1 && t < 10) begin
      @(posedge TxClk); #1;
      t++;
    end
    if (t >= 10) chk("gnt_drop", 32'(b ? GntB : GntA), 0);
  endtask
  initial begin
    logic pa, pb;
    logic [8:0] e;
    gexp_t ge;
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge TxClk);
      if (TxEn === 1'b1) begin
        if (bq.size() == 0) chk("extra_byte", 32'(TxD), 32'hffff_ffff);
        else begin
          e = bq.pop_front();
          chk("txd", 32'(TxD), 32'(e[7:0]));
          chk("txerr", 32'(TxErr), 32'(e[8]));
        end
      end
      if ((GntA && !pa) || (GntB && !pb)) begin
        if (gq.size() == 0) chk("extra_grant", 32'({GntA, GntB}), 0);
        else begin
          ge = gq.pop_front();
          chk("gnt_port", 32'(GntB), 32'(ge.b));
          if (ge.gap >= 0) chk("gnt_gap", glow, ge.gap);
        end
        glow = 0;
      end else if (!GntA && !GntB) glow++;
      if (GntA && GntB) chk("gnt_both", 32'({GntA, GntB}), 32'b10);
      if (Jabber) jab_n++;
      pa = GntA;
      pb = GntB;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge TxClk);
    #1;
    chk("rst_gnt", 32'({GntA, GntB}), 0);
    chk("rst_txen", 32'(TxEn), 0);
    chk("rst_txd", 32'(TxD), 0);
    chk("rst_txerr", 32'(TxErr), 0);
    chk("rst_jabber", 32'(Jabber), 0);
    chk("rst_fcnt", 32'({FrameCntA, FrameCntB}), 0);
    rst_n = 1'b1;
    chk("clken_pre", 32'(ClkEN), 0);
    @(posedge TxClk); #1;
    chk("clken_post", 32'(ClkEN), 1);
    // A alone, 64 bytes, error on byte index 10
    gq.push_back('{1'b0, -1});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge TxClk); #1;
    chk("gnt_latency", 32'(GntA), 1);
    frame(1'b0, 64, 10, 64);
    ReqA = 1'b0;
    repeat (20) @(posedge TxClk);
    #1;
    // A granted then released without a frame; pending B follows immediately
    gq.push_back('{1'b0, -1});
    gq.push_back('{1'b1, 1});
    ReqA = 1'b1;
    wait_gnt(1'b0);
    ReqB = 1'b1;
    @(posedge TxClk); #1;
    ReqA = 1'b0;
    frame(1'b1, 20, -1, 20);
    // both requesting from inside B's IFG: A, B, A with full gaps
    gq.push_back('{1'b0, GAP});
    gq.push_back('{1'b1, GAP});
    gq.push_back('{1'b0, GAP});
    fork
      begin
        frame(1'b0, 16, -1, 16);
        frame(1'b0, 16, 3, 16);
        ReqA = 1'b0;
      end
      begin
        frame(1'b1, 16, -1, 16);
        ReqB = 1'b0;
      end
    join
    repeat (20) @(posedge TxClk);
    #1;
    chk("fcnt_b_pre", 32'(FrameCntB), STATS * 2);
    // B overlong frame cut at the jabber limit
    gq.push_back('{1'b1, -1});
    frame(1'b1, 1600, -1, JABBER_DEFAULT);
    ReqB = 1'b0;
    repeat (20) @(posedge TxClk);
    #1;
    chk("jabber_pulses", jab_n, 1);
    chk("fcnt_b", 32'(FrameCntB), STATS * 3);
    chk("fcnt_a", 32'(FrameCntA), STATS * 3);
    // reset during byte 30 of an A frame
    gq.push_back('{1'b0, -1});
    ReqA = 1'b1;
    wait_gnt(1'b0);
    for (int i = 0; i < 30; i++) begin
      TxEnA = 1'b1;
      TxDA = 8'(i + 8'h40);
      bq.push_back({1'b0, TxDA});
      @(posedge TxClk); #1;
    end
    TxDA = 8'h5e;
    #6;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'({GntA, GntB}), 0);
    chk("mid_rst_txen", 32'(TxEn), 0);
    chk("mid_rst_txd", 32'(TxD), 0);
    chk("mid_rst_txerr", 32'(TxErr), 0);
    chk("mid_rst_clken", 32'(ClkEN), 0);
    chk("mid_rst_jabber", 32'(Jabber), 0);
    TxEnA = 1'b0;
    gq.push_back('{1'b0, -1});
    @(posedge TxClk); #1;
    chk("rst_hold_clken", 32'(ClkEN), 0);
    chk("rst_hold_fcnt", 32'({FrameCntA, FrameCntB}), 0);
    rst_n = 1'b1;
    @(posedge TxClk); #1;
    chk("rel_clken", 32'(ClkEN), 1);
    chk("rel_grant", 32'(GntA), 1);
    ReqA = 1'b0;
    repeat (5) @(posedge TxClk);
    #1;
    chk("bytes_left", bq.size(), 0);
    chk("grants_left", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
